// File: rtl/width_pkg.sv
// rtl/width_pkg.sv - mode encodings and helpers shared by the width packer
package width_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ZEXT    = 2'b00;
    localparam mode_t MODE_LALIGN  = 2'b01;
    localparam mode_t MODE_PACK_LO = 2'b10;
    localparam mode_t MODE_PACK_HI = 2'b11;

    // Packing modes gather several words per output; the others emit one word per accept.
    function automatic logic is_pack(input mode_t m);
        return m[1];
    endfunction

endpackage

// File: rtl/lane_insert.sv
// rtl/lane_insert.sv - writes one IN_W word into a selected lane of an OUT_W vector
module lane_insert #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int LANE_W = 2
) (
    input  logic [OUT_W-1:0]  base,
    input  logic [IN_W-1:0]   word,
    input  logic [LANE_W-1:0] lane,
    output logic [OUT_W-1:0]  result
);

    localparam int RATIO = OUT_W / IN_W;

    // Copy the base vector and overwrite only the addressed lane.
    always_comb begin
        result = base;
        for (int k = 0; k < RATIO; k++) begin
            if (lane == LANE_W'(k)) begin
                result[k*IN_W +: IN_W] = word;
            end
        end
    end

endmodule

// File: rtl/width_packer.sv
// rtl/width_packer.sv - streaming IN_W to OUT_W width adapter with zext/align/pack modes
module width_packer
    import width_pkg::*;
#(
    parameter  int IN_W  = 16,
    parameter  int OUT_W = 32,
    localparam int RATIO = OUT_W / IN_W,
    localparam int CNT_W = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    // Lanes must tile the output word exactly.
    generate
        if ((OUT_W % IN_W) != 0 || RATIO < 1) begin : g_bad_widths
            $error("width_packer: OUT_W must be a non-zero multiple of IN_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    logic [OUT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    mode_t            lmode;

    mode_t            cur_mode;
    logic             single;
    logic [CNT_W-1:0] lane;
    logic [OUT_W-1:0] base;
    logic [OUT_W-1:0] ins;
    logic             accept;
    logic             flush_take;
    logic             complete;
    logic             emit;
    logic [CNT_W-1:0] next_count;
    logic [OUT_W-1:0] next_data;

    // Single output register with no skid: a new word may enter only when the slot frees this cycle.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign flush_take = flush && in_ready;

    // A packet takes its mode from the first word; later mode changes wait for the next packet.
    assign cur_mode = (cnt == '0) ? mode_t'(mode) : lmode;
    assign single   = !is_pack(cur_mode);

    // Lane the incoming word lands in, by mode and position within the packet.
    always_comb begin
        lane = '0;
        case (cur_mode)
            MODE_ZEXT:    lane = '0;
            MODE_LALIGN:  lane = LAST;
            MODE_PACK_LO: lane = cnt;
            MODE_PACK_HI: lane = LAST - cnt;
            default:      lane = '0;
        endcase
    end

    assign base = single ? '0 : acc;

    lane_insert #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .LANE_W (CNT_W)
    ) u_lane_insert (
        .base   (base),
        .word   (in_data),
        .lane   (lane),
        .result (ins)
    );

    // Emit on the word that fills the packet, or on a flush that has something to send.
    assign complete   = accept && (single || cnt == LAST);
    assign emit       = complete || (flush_take && (accept || cnt != '0));
    assign next_count = accept ? (single ? CNT_W'(1) : cnt + CNT_W'(1)) : cnt;
    assign next_data  = accept ? ins : acc;

    // Accumulator, lane count and per-packet mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            lmode <= MODE_ZEXT;
        end else begin
            if (accept && cnt == '0) begin
                lmode <= mode_t'(mode);
            end
            if (emit) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= ins;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output register: loads on emit, holds while stalled, drops valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= next_data;
                out_count <= next_count;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_width_packer.sv
// tb/tb_width_packer.sv - directed self-checking bench for width_packer
module tb_width_packer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    logic [1:0]  mode_w;
    logic        in_valid_w;
    logic        in_ready_w;
    logic [15:0] in_data_w;
    logic        flush_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] out_data_w;
    logic [1:0]  out_count_w;

    int checks;
    int errors;

    width_packer #(.IN_W(8), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    width_packer #(.IN_W(16), .OUT_W(32)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_w),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .in_data   (in_data_w),
        .flush     (flush_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w),
        .out_data  (out_data_w),
        .out_count (out_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word (optionally with flush) and hold it until accepted.
    task automatic send(input logic [7:0] word, input logic [1:0] md, input logic fl);
        int waits;
        in_valid = 1'b1;
        in_data  = word;
        mode     = md;
        flush    = fl;
        waits    = 0;
        while (!in_ready && waits < 20) begin
            tick();
            waits++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] data, input logic [2:0] cnt);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, data);
        check({tag, "_count"}, {29'd0, out_count}, {29'd0, cnt});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        mode        = 2'b00;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        flush       = 1'b0;
        out_ready   = 1'b1;
        mode_w      = 2'b00;
        in_valid_w  = 1'b0;
        in_data_w   = 16'h0000;
        flush_w     = 1'b0;
        out_ready_w = 1'b1;

        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_count", {29'd0, out_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a PACK_LO packet discards it.
        send(8'hAA, 2'b10, 1'b0);
        send(8'hBB, 2'b10, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data", out_data, 32'd0);
        check("midrst_count", {29'd0, out_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h11, 2'b10, 1'b0);
        send(8'h22, 2'b10, 1'b0);
        send(8'h33, 2'b10, 1'b0);
        check("partial_no_out", {31'd0, out_valid}, 32'd0);
        send(8'h44, 2'b10, 1'b0);
        expect_out("after_rst", 32'h44332211, 3'd4);

        // Single-word modes.
        send(8'hA5, 2'b00, 1'b0);
        expect_out("zext", 32'h000000A5, 3'd1);
        send(8'hA5, 2'b01, 1'b0);
        expect_out("lalign", 32'hA5000000, 3'd1);

        // PACK_HI.
        send(8'h11, 2'b11, 1'b0);
        send(8'h22, 2'b11, 1'b0);
        send(8'h33, 2'b11, 1'b0);
        send(8'h44, 2'b11, 1'b0);
        expect_out("pack_hi", 32'h11223344, 3'd4);

        // Continuous stream of 8 words, one per cycle.
        mode     = 2'b10;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i + 1);
            check("stream_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("stream_valid", {31'd0, out_valid}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
            if (i == 3) check("stream_pkt0", out_data, 32'h04030201);
            if (i == 7) check("stream_pkt1", out_data, 32'h08070605);
        end
        in_valid = 1'b0;
        tick();

        // Flush a two-word partial packet.
        send(8'h11, 2'b10, 1'b0);
        send(8'h22, 2'b10, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_out("flush2", 32'h00002211, 3'd2);

        // Flush together with an accept.
        send(8'h11, 2'b10, 1'b0);
        send(8'h22, 2'b10, 1'b0);
        send(8'h33, 2'b10, 1'b1);
        expect_out("flush_acc", 32'h00332211, 3'd3);
        tick();

        // Flush with nothing buffered emits nothing.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty0", {31'd0, out_valid}, 32'd0);
        tick();
        check("flush_empty1", {31'd0, out_valid}, 32'd0);

        // Backpressure with a pending packet and a held word+flush.
        out_ready = 1'b0;
        send(8'h11, 2'b10, 1'b0);
        send(8'h22, 2'b10, 1'b0);
        send(8'h33, 2'b10, 1'b0);
        send(8'h44, 2'b10, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        flush    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            expect_out("bp_hold", 32'h44332211, 3'd4);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        expect_out("bp_resume", 32'h00000055, 3'd1);
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Mode change mid-packet is ignored until the packet completes.
        send(8'h11, 2'b10, 1'b0);
        send(8'h22, 2'b00, 1'b0);
        check("modechg_no_out", {31'd0, out_valid}, 32'd0);
        send(8'h33, 2'b00, 1'b0);
        send(8'h44, 2'b00, 1'b0);
        expect_out("modechg_pkt", 32'h44332211, 3'd4);
        send(8'h66, 2'b00, 1'b0);
        expect_out("modechg_zext", 32'h00000066, 3'd1);
        tick();

        // 16-bit input build.
        mode_w     = 2'b00;
        in_data_w  = 16'h1234;
        in_valid_w = 1'b1;
        check("w16_ready", {31'd0, in_ready_w}, 32'd1);
        tick();
        in_valid_w = 1'b0;
        check("w16_valid", {31'd0, out_valid_w}, 32'd1);
        check("w16_data", out_data_w, 32'h00001234);
        check("w16_count", {30'd0, out_count_w}, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
